// File: rtl/dec_line_tx_pkg.sv
// dec_line_tx_pkg: shared constants and state types for the decimal line
// transmitter (dec_line_tx) and its byte serialiser.
package dec_line_tx_pkg;

  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Line-transmit FSM states.
  typedef enum logic [2:0] {
    T_IDLE = 3'd0,
    T_LOAD = 3'd1,
    T_SEND = 3'd2,
    T_NEXT = 3'd3,
    T_DONE = 3'd4
  } tx_state_e;

  // Ping-pong line buffer ownership.
  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_e;

endpackage

// File: rtl/dec_line_tx_if.sv
// dec_line_tx_if: digit-stream handshake between the binary-to-decimal
// converter (master) and dec_line_tx (slave).
//   in_data  [7:0] ASCII digit, most significant first
//   in_valid       one cycle per digit; consecutive cycles form a burst
//   in_ready       at least one line buffer is free
interface dec_line_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/dec_line_tx_uart.sv
// uart_tx_byte: 8N1 byte serialiser, every bit CLKS_PER_BIT cycles.
//   clk, rst   clock, synchronous active-high reset
//   start      launch a frame with data (accepted when idle or on done)
//   data[7:0]  byte to send, LSB first
//   tx         serial line, idles high
//   done       one-cycle pulse during the last cycle of the stop bit
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic          active_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    bit_q;    // 0 start, 1..8 data, 9 stop
  logic [8:0]    shreg_q;  // remaining data bits with the stop bit on top
  logic          tx_q;

  assign done = active_q && (bit_q == 4'd9) && (cnt_q == CNT_LAST);
  assign tx   = tx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '1;
      tx_q     <= 1'b1;
    end else if (start && (!active_q || done)) begin
      // Accepting on done chains frames with no idle time between them.
      active_q <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= {1'b1, data};
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        if (bit_q == 4'd9) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shreg_q[0];
          shreg_q <= {1'b1, shreg_q[8:1]};
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dec_line_tx.sv
// dec_line_tx: captures ASCII digit bursts into two ping-pong line buffers,
// appends CR LF and sends each line over an 8N1 UART, oldest line first.
//   clk, rst   clock, synchronous active-high reset
//   up         dec_line_tx_if.slave digit stream (in_data/in_valid/in_ready)
//   tx         UART serial line, idles high
//   busy       a line is buffered or being transmitted
//   overflow   sticky: a burst started with no free buffer
// Build option: DEC_LINE_TX_LZS_EN skips leading '0' characters of a line
// (the last digit is always sent).
module dec_line_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DIGITS       = 5
) (
  input  logic           clk,
  input  logic           rst,
  dec_line_tx_if.slave   up,
  output logic           tx,
  output logic           busy,
  output logic           overflow
);
  import dec_line_tx_pkg::*;

  localparam int unsigned IW = $clog2(DIGITS + 2);
  typedef logic [IW-1:0] idx_t;

  logic [7:0] mem_q [2][DIGITS];
  buf_state_e bst_q [2];
  idx_t       cnt_q [2];
  logic       claim_ptr_q, tx_ptr_q, cap_buf_q, in_burst_q, drop_q, overflow_q;
  logic [1:0] free_now;

  tx_state_e  st_q, st_d;
  idx_t       idx_q, idx_d, first_idx, sel_idx, line_cnt;
  logic       first_q, first_d;
  logic       ustart, udone;
  logic [7:0] ubyte;

  // A buffer released by T_DONE this cycle may be claimed in the same cycle.
  always_comb begin
    free_now[0] = (bst_q[0] == FREE) || ((st_q == T_DONE) && !tx_ptr_q);
    free_now[1] = (bst_q[1] == FREE) || ((st_q == T_DONE) &&  tx_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bst_q[0]    <= FREE;
      bst_q[1]    <= FREE;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      claim_ptr_q <= 1'b0;
      cap_buf_q   <= 1'b0;
      in_burst_q  <= 1'b0;
      drop_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (st_q == T_DONE) bst_q[tx_ptr_q] <= FREE;
      if (up.in_valid && !in_burst_q) begin
        in_burst_q <= 1'b1;
        if (free_now[claim_ptr_q]) begin
          bst_q[claim_ptr_q] <= FILLING;
          cnt_q[claim_ptr_q] <= idx_t'(1);
          cap_buf_q          <= claim_ptr_q;
          claim_ptr_q        <= ~claim_ptr_q;
          drop_q             <= 1'b0;
        end else begin
          drop_q     <= 1'b1;
          overflow_q <= 1'b1;
        end
      end else if (up.in_valid) begin
        if (!drop_q && (cnt_q[cap_buf_q] < idx_t'(DIGITS)))
          cnt_q[cap_buf_q] <= cnt_q[cap_buf_q] + 1'b1;
      end else if (in_burst_q) begin
        in_burst_q <= 1'b0;
        if (!drop_q) bst_q[cap_buf_q] <= FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (up.in_valid && !in_burst_q && free_now[claim_ptr_q]) begin
      mem_q[claim_ptr_q][0] <= up.in_data;
    end else if (up.in_valid && in_burst_q && !drop_q) begin
      for (int unsigned p = 0; p < DIGITS; p++)
        if (cnt_q[cap_buf_q] == idx_t'(p)) mem_q[cap_buf_q][p] <= up.in_data;
    end
  end

  // Character feeding the serialiser: the line's first character on the
  // launch cycle, otherwise the one after the character now on the wire.
  always_comb begin
    line_cnt = cnt_q[tx_ptr_q];
    sel_idx  = first_q ? idx_q : idx_q + 1'b1;
    ubyte    = ASCII_LF;
    if (sel_idx == line_cnt) ubyte = ASCII_CR;
    for (int unsigned p = 0; p < DIGITS; p++)
      if ((sel_idx == idx_t'(p)) && (sel_idx < line_cnt)) ubyte = mem_q[tx_ptr_q][p];
  end

  always_comb begin
`ifdef DEC_LINE_TX_LZS_EN
    // Scan from the top so the lowest non-zero position wins.
    first_idx = line_cnt - 1'b1;
    for (int unsigned q = 0; q < DIGITS; q++) begin
      if ((idx_t'(DIGITS - 1 - q) < line_cnt - 1'b1) &&
          (mem_q[tx_ptr_q][DIGITS - 1 - q] != ASCII_ZERO))
        first_idx = idx_t'(DIGITS - 1 - q);
    end
`else
    first_idx = '0;
`endif
  end

  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    first_d = first_q;
    ustart  = 1'b0;
    case (st_q)
      T_IDLE: if (bst_q[tx_ptr_q] == FULL) st_d = T_LOAD;
      T_LOAD: begin
        idx_d   = first_idx;
        first_d = 1'b1;
        st_d    = T_SEND;
      end
      T_SEND: begin
        if (first_q) begin
          ustart  = 1'b1;
          first_d = 1'b0;
        end else if (udone) begin
          if (idx_q == line_cnt + 1'b1) begin
            st_d = T_DONE;
          end else begin
            // Next byte launches on the done cycle so frames abut.
            ustart = 1'b1;
            st_d   = T_NEXT;
          end
        end
      end
      T_NEXT: begin
        idx_d = idx_q + 1'b1;
        st_d  = T_SEND;
      end
      T_DONE:  st_d = T_IDLE;
      default: st_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= T_IDLE;
      idx_q    <= '0;
      first_q  <= 1'b0;
      tx_ptr_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      if (st_q == T_DONE) tx_ptr_q <= ~tx_ptr_q;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk   (clk),
    .rst   (rst),
    .start (ustart),
    .data  (ubyte),
    .tx    (tx),
    .done  (udone)
  );

  assign up.in_ready = (bst_q[0] == FREE) || (bst_q[1] == FREE);
  assign busy        = (bst_q[0] != FREE) || (bst_q[1] != FREE) || (st_q != T_IDLE);
  assign overflow    = overflow_q;
endmodule

// File: doc/dec_line_tx.md
# dec_line_tx

Downstream consumer of the decimal digit stream produced by the binary-to-decimal converter. It captures each burst of ASCII digits into a ping-pong line buffer, appends CR LF, and serialises the line over an 8N1 UART. Two line buffers allow the next conversion to land while the previous line is still on the wire. Sits between the converter and the board UART pin.

## Interface
- CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- DIGITS, default 5, maximum digits per line; extra characters in a burst are dropped.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  8  ASCII digit, most significant first.
- in_valid  input  1  high for one cycle per digit; a burst is consecutive high cycles.
- in_ready  output  1  high when at least one line buffer is free; upstream starts a conversion only while high.
- tx  output  1  UART serial line; idles high.
- busy  output  1  high while any line is buffered or transmitting.
- overflow  output  1  sticky; set when a burst arrives with no free buffer; cleared only by rst.

## Operation
- Capture side:
  - On the first in_valid cycle, claim the free buffer (index A first, then alternate); write in_data at position 0.
  - Each further in_valid cycle writes the next position and increments the count, saturating at DIGITS (excess discarded, no flag).
  - The first in_valid-low cycle after at least one digit closes the burst: the buffer is marked full with its count and queued.
  - If no buffer is free at burst start, the whole burst is discarded and overflow is set.
- Transmit side FSM: T_IDLE → T_LOAD → T_SEND → T_NEXT → T_SEND … → T_DONE → T_IDLE.
  - T_IDLE: waits for a full buffer, oldest first.
  - T_LOAD: selects the character index.
  - T_SEND: holds until the byte serialiser finishes.
  - T_NEXT: advances through digits 0..count-1, then 8'h0D, then 8'h0A.
  - T_DONE: frees the buffer and returns to T_IDLE.
- Serialiser frame, every bit exactly CLKS_PER_BIT cycles:
  - start bit 0;
  - data bits LSB first;
  - stop bit 1, then tx stays high.
- Line length on the wire: count+2 bytes; back-to-back bytes have no extra idle bits.
- in_ready = NOT(both buffers full-or-capturing).
- busy = any buffer not free OR FSM not in T_IDLE.
- Reset values: tx=1, in_ready=1, busy=0, overflow=0, both buffers free, FSM T_IDLE.
- Reset asserted mid-frame: tx returns high on the next edge and all buffered data is lost.
- Simultaneous events: a buffer freed in T_DONE in the same cycle a new burst starts is claimable in that cycle (free is evaluated combinationally before capture).

## Timing
- in_data and in_valid are sampled on the rising edge; upstream may update them on the falling edge (half-cycle setup).
- Start bit (tx falling) begins 3 cycles after the first in_valid-low edge that closes a burst, when the transmit side is idle: close, queue, T_LOAD.
- in_ready deasserts the cycle after the second buffer is claimed and reasserts the cycle after T_DONE frees a buffer.
- Line time: (count+2) × 10 × CLKS_PER_BIT cycles, plus 3 cycles of FSM overhead per line.

## Configuration
- DEC_LINE_TX_LZS_EN defined: leading '0' (8'h30) characters of each line are skipped at transmit time; the last digit is always sent, so "00000" transmits "0" CR LF.
- Undefined: every captured digit is transmitted verbatim.

## Structure
- Package dec_line_tx_pkg holds:
  - constants ASCII_CR=8'h0D, ASCII_LF=8'h0A, ASCII_ZERO=8'h30;
  - the transmit FSM state enum;
  - the buffer-state enum (FREE, FILLING, FULL).
- One sub-module, uart_tx_byte, with ports clk, rst, start, data[7:0], tx, done and a CLKS_PER_BIT parameter.
  - done pulses for one cycle at the end of the stop bit.
- Top level holds the ping-pong buffers, the capture logic and the line FSM.

## Test plan
- CLKS_PER_BIT=4, burst "0","1","2","3","4" → tx carries 8'h30,31,32,33,34,0D,0A; each bit 4 cycles; busy drops after the last stop bit.
- Two bursts "65535" and "00042" back-to-back → both lines are sent in order; in_ready stays high until the second capture; overflow stays 0.
- Three bursts with no gap while the first line transmits → third burst is dropped; overflow=1; first two lines intact.
- Seven-digit burst with DIGITS=5 → only the first five digits are transmitted, followed by CR LF.
- With DEC_LINE_TX_LZS_EN, burst "00042" → "42" CR LF; burst "00000" → "0" CR LF.
- rst pulsed during the third data bit → tx=1 next cycle, busy=0, in_ready=1, and nothing further is sent.
